// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch producer feeding the IF/ID register.
// Owns the PC and keeps at most one instruction-memory request in flight.
// It has a single registered output slot with decode stall backpressure.
// A redirect kills any fetch that is still in flight.
// Optional build macro FETCH_PERF_CNT_EN adds two counter outputs:
// consumed instructions and discarded responses.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic [31:0] instrCode,
    output logic [31:0] PC_IF,
    output logic        if_valid_o,
    input  logic        id_stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [15:0] perf_kill_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        KILL     = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_if;
    logic        r_valid;

    logic        w_slot_free;
    logic        w_consume;
    logic        w_req_valid;
    logic        w_req_fire;
    logic        w_rsp_accept;
    logic        w_rsp_drop;

    // Handshake qualifiers and next-state selection
    always_comb begin
        w_slot_free  = !r_valid || !id_stall_i;
        w_consume    = r_valid && !id_stall_i;
        // Gated by rst so the request stays low while reset is held.
        w_req_valid  = rst && (r_state == IDLE) && w_slot_free && !redirect_i;
        w_req_fire   = w_req_valid && imem_req_ready_i;
        w_rsp_accept = (r_state == WAIT_RSP) && imem_rsp_valid_i && !redirect_i;
        w_rsp_drop   = imem_rsp_valid_i &&
                       ((r_state == KILL) || ((r_state == WAIT_RSP) && redirect_i));
        w_state_nxt  = r_state;
        case (r_state)
            IDLE: begin
                if (w_req_fire) begin
                    w_state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (imem_rsp_valid_i) begin
                    w_state_nxt = IDLE;
                end else if (redirect_i) begin
                    w_state_nxt = KILL;
                end
            end
            KILL: begin
                if (imem_rsp_valid_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, request address capture and IF/ID output slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
            r_instr  <= '0;
            r_pc_if  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_req_fire) begin
                r_req_pc <= r_pc;
            end
            if (redirect_i) begin
                r_valid <= 1'b0;
                r_pc    <= redirect_pc_i & 32'hFFFF_FFFC;
            end else if (w_rsp_accept) begin
                r_valid <= 1'b1;
                r_instr <= imem_rsp_data_i;
                r_pc_if <= r_req_pc;
                r_pc    <= r_req_pc + 32'd4;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [15:0] r_kill_cnt;

    // Wrapping counters of consumed instructions and discarded responses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_cnt <= '0;
            r_kill_cnt  <= '0;
        end else begin
            if (w_consume) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_rsp_drop) begin
                r_kill_cnt <= r_kill_cnt + 16'd1;
            end
        end
    end

    assign perf_fetch_cnt_o = r_fetch_cnt;
    assign perf_kill_cnt_o  = r_kill_cnt;
`endif

    assign imem_req_valid_o = w_req_valid;
    assign imem_addr_o      = r_pc;
    assign instrCode        = r_instr;
    assign PC_IF            = r_pc_if;
    assign if_valid_o       = r_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit. It has a fetch-level reference model and a
// memory responder with programmable latency. Directed phases cover
// stall, redirect, reset and wrap-around.
module tb_if_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic [31:0] instrCode;
    logic [31:0] PC_IF;
    logic        if_valid_o;
    logic        id_stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [15:0] perf_kill_cnt_o;
`endif

    // second instance: wrap-around of the PC from RESET_PC=0xFFFF_FFFC
    logic        w2_req_valid;
    logic        w2_ready;
    logic [31:0] w2_addr;
    logic        w2_rsp_valid;
    logic [31:0] w2_rsp_data;
    logic [31:0] w2_instr;
    logic [31:0] w2_pc_if;
    logic        w2_valid;
    logic        w2_stall;
    logic        w2_redirect;
    logic [31:0] w2_redirect_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] w2_perf_fetch;
    logic [15:0] w2_perf_kill;
`endif

    int checks;
    int fails;

    if_fetch_unit #(.RESET_PC(RPC)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .instrCode        (instrCode),
        .PC_IF            (PC_IF),
        .if_valid_o       (if_valid_o),
        .id_stall_i       (id_stall_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_kill_cnt_o  (perf_kill_cnt_o)
`endif
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid_o (w2_req_valid),
        .imem_req_ready_i (w2_ready),
        .imem_addr_o      (w2_addr),
        .imem_rsp_valid_i (w2_rsp_valid),
        .imem_rsp_data_i  (w2_rsp_data),
        .instrCode        (w2_instr),
        .PC_IF            (w2_pc_if),
        .if_valid_o       (w2_valid),
        .id_stall_i       (w2_stall),
        .redirect_i       (w2_redirect),
        .redirect_pc_i    (w2_redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o (w2_perf_fetch),
        .perf_kill_cnt_o  (w2_perf_kill)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int unsigned mem_lat;
    int unsigned mem_cnt;
    logic [31:0] mem_addr;
    logic        mem_hs;
    logic [31:0] mem_hs_addr;

    initial begin
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        mem_cnt          = 0;
        mem_addr         = '0;
        forever begin
            @(negedge clk);
            mem_hs      = rst && imem_req_valid_o && imem_req_ready_i;
            mem_hs_addr = imem_addr_o;
            @(posedge clk);
            #1;
            imem_rsp_valid_i = 1'b0;
            if (!rst) begin
                mem_cnt = 0;
            end else begin
                if (mem_cnt != 0) begin
                    mem_cnt--;
                    if (mem_cnt == 0) begin
                        imem_rsp_valid_i = 1'b1;
                        imem_rsp_data_i  = memfn(mem_addr);
                    end
                end
                if (mem_hs) begin
                    if (mem_lat <= 1) begin
                        imem_rsp_valid_i = 1'b1;
                        imem_rsp_data_i  = memfn(mem_hs_addr);
                    end else begin
                        mem_cnt  = mem_lat - 1;
                        mem_addr = mem_hs_addr;
                    end
                end
            end
        end
    end

    // ---------------- 1-cycle responder for the wrap instance ----------------
    logic        w2_hs;
    logic [31:0] w2_hs_addr;
    logic [31:0] w2_log[$];

    initial begin
        w2_ready       = 1'b1;
        w2_stall       = 1'b0;
        w2_redirect    = 1'b0;
        w2_redirect_pc = '0;
        w2_rsp_valid   = 1'b0;
        w2_rsp_data    = '0;
        forever begin
            @(negedge clk);
            w2_hs      = rst && w2_req_valid && w2_ready;
            w2_hs_addr = w2_addr;
            if (w2_hs) w2_log.push_back(w2_hs_addr);
            @(posedge clk);
            #1;
            w2_rsp_valid = w2_hs && rst;
            w2_rsp_data  = memfn(w2_hs_addr);
        end
    end

    // ---------------- reference model and per-cycle compare ----------------
    // The model tracks the fetch at transaction level: the next address, one
    // outstanding request (possibly doomed), and the decode-facing slot.
    logic [31:0] m_pc, m_req_pc, m_ins, m_pcif;
    logic        m_busy, m_discard, m_vld;
    logic [31:0] m_fetch;
    logic [15:0] m_kill;
    logic        exp_req, m_consume, m_hs;
    logic [31:0] hs_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_pc = RPC; m_req_pc = '0; m_ins = '0; m_pcif = '0;
                m_busy = 1'b0; m_discard = 1'b0; m_vld = 1'b0;
                m_fetch = '0; m_kill = '0;
            end
            exp_req = rst && !m_busy && (!m_vld || !id_stall_i) && !redirect_i;
            chk("req_valid", {31'd0, imem_req_valid_o}, {31'd0, exp_req});
            chk("addr", imem_addr_o, m_pc);
            chk("if_valid", {31'd0, if_valid_o}, {31'd0, m_vld});
            chk("instrCode", instrCode, m_ins);
            chk("PC_IF", PC_IF, m_pcif);
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetch", perf_fetch_cnt_o, m_fetch);
            chk("perf_kill", {16'd0, perf_kill_cnt_o}, {16'd0, m_kill});
`endif
            if (rst) begin
                m_consume = m_vld && !id_stall_i;
                m_hs      = exp_req && imem_req_ready_i;
                if (m_hs) hs_log.push_back(imem_addr_o);
                if (m_consume) begin
                    m_fetch = m_fetch + 32'd1;
                    m_vld   = 1'b0;
                end
                if (redirect_i) begin
                    m_vld = 1'b0;
                    m_pc  = {redirect_pc_i[31:2], 2'b00};
                    if (m_busy) begin
                        if (imem_rsp_valid_i) begin
                            m_busy = 1'b0;
                            m_kill = m_kill + 16'd1;
                        end else begin
                            m_discard = 1'b1;
                        end
                    end
                end else if (m_busy && imem_rsp_valid_i) begin
                    m_busy = 1'b0;
                    if (m_discard) begin
                        m_kill = m_kill + 16'd1;
                    end else begin
                        m_vld  = 1'b1;
                        m_ins  = imem_rsp_data_i;
                        m_pcif = m_req_pc;
                        m_pc   = m_req_pc + 32'd4;
                    end
                end else if (m_hs) begin
                    m_busy    = 1'b1;
                    m_discard = 1'b0;
                    m_req_pc  = m_pc;
                end
            end
        end
    end

    task automatic wait_hs(output logic [31:0] a);
        int unsigned n;
        n = 0;
        a = '0;
        forever begin
            @(negedge clk);
            if (imem_req_valid_o && imem_req_ready_i) begin
                a = imem_addr_o;
                return;
            end
            n++;
            if (n > 60) begin
                checks++;
                fails++;
                $display("FAIL wait_hs: got no handshake in 60 cycles, required one");
                return;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    logic [31:0] a;
    logic [15:0] kbase;
    logic [23:0] stall_pat;
    logic [23:0] ready_pat;

    initial begin
        checks = 0;
        fails  = 0;
        rst = 1'b0;
        imem_req_ready_i = 1'b1;
        id_stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        mem_lat = 1;
        kbase = '0;

        // reset values
        repeat (2) step();
        chk("rst_if_valid", {31'd0, if_valid_o}, 32'd0);
        chk("rst_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
        chk("rst_PC_IF", PC_IF, 32'd0);
        chk("rst_instr", instrCode, 32'd0);
        chk("rst_addr", imem_addr_o, 32'h0000_0100);
        rst = 1'b1;

        // first fetch, then decode stalls for the following cycles
        wait_hs(a);
        chk("first_req", a, 32'h0000_0100);
        step();
        id_stall_i = 1'b1;
        repeat (6) @(negedge clk);
        chk("stall_valid", {31'd0, if_valid_o}, 32'd1);
        chk("stall_PC_IF", PC_IF, 32'h0000_0100);
        chk("stall_instr", instrCode, 32'h0100_FFFF ^ 32'h5A5A_0F0F);
        chk("stall_no_req", hs_log.size(), 32'd1);
        step();
        id_stall_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("seq_req1", (hs_log.size() > 1) ? hs_log[1] : 32'hDEAD_0001, 32'h0000_0104);
        chk("seq_req2", (hs_log.size() > 2) ? hs_log[2] : 32'hDEAD_0002, 32'h0000_0108);

        // redirect while the request is in flight: response is discarded
        mem_lat = 3;
        step();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        step();
        redirect_i = 1'b0;
        wait_hs(a);
        chk("redir_req", a, 32'h0000_0200);
        kbase = m_kill;
        step();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0403;
        step();
        redirect_i = 1'b0;
        wait_hs(a);
        chk("kill_next_req", a, 32'h0000_0400);
`ifdef FETCH_PERF_CNT_EN
        chk("kill_cnt", {16'd0, perf_kill_cnt_o}, {16'd0, kbase + 16'd1});
`endif

        // redirect in the same cycle as the response
        mem_lat = 2;
        wait_hs(a);
        kbase = m_kill;
        step();
        step();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0080;
        step();
        redirect_i = 1'b0;
        @(negedge clk);
        chk("same_cyc_valid", {31'd0, if_valid_o}, 32'd0);
        chk("same_cyc_req", {31'd0, imem_req_valid_o}, 32'd1);
        chk("same_cyc_addr", imem_addr_o, 32'h0000_0080);
`ifdef FETCH_PERF_CNT_EN
        chk("same_cyc_kill", {16'd0, perf_kill_cnt_o}, {16'd0, kbase + 16'd1});
`endif

        // mixed stall / ready pattern with one redirect
        mem_lat = 1;
        stall_pat = 24'b0010_1100_0111_0000_1011_0100;
        ready_pat = 24'b1101_1111_0110_1111_1011_1111;
        for (int i = 0; i < 24; i++) begin
            step();
            id_stall_i = stall_pat[i];
            imem_req_ready_i = ready_pat[i];
            redirect_i = (i == 13);
            redirect_pc_i = 32'h0000_03FE;
            if (i == 12) mem_lat = 2;
        end
        step();
        id_stall_i = 1'b0;
        imem_req_ready_i = 1'b1;
        redirect_i = 1'b0;

        // asynchronous reset while a response is outstanding
        mem_lat = 4;
        wait_hs(a);
        step();
        rst = 1'b0;
        #1;
        chk("arst_if_valid", {31'd0, if_valid_o}, 32'd0);
        chk("arst_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
        chk("arst_PC_IF", PC_IF, 32'd0);
        chk("arst_instr", instrCode, 32'd0);
        chk("arst_addr", imem_addr_o, 32'h0000_0100);
        repeat (2) step();
        rst = 1'b1;
        mem_lat = 1;
        wait_hs(a);
        chk("arst_first_req", a, 32'h0000_0100);
        repeat (6) @(negedge clk);

        // PC wrap on the second instance
        chk("wrap_req0", (w2_log.size() > 0) ? w2_log[0] : 32'hDEAD_0003, 32'hFFFF_FFFC);
        chk("wrap_req1", (w2_log.size() > 1) ? w2_log[1] : 32'hDEAD_0004, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
